mult_div_unit: RTL and testbench

Iterative signed multiply/divide unit that sits directly downstream of the multicycle control unit. It consumes the control unit's MULT_OP/DIV_OP strobes and the A/B register operands. It produces the 64-bit result that is written into the HI/LO registers. Completion is signalled by a done pulse, so the controller waits on done rather than on a private count.

---
 rtl/mult_div_pkg.sv | 18 +
 rtl/div_magnitude_core.sv | 28 ++
 rtl/mult_div_unit.sv | 166 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared constants, state codes and helpers for the iterative signed multiply/divide unit.
package mult_div_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITERS = WIDTH;
    localparam int unsigned CNT_W = $clog2(ITERS);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MULT_RUN = 2'd1;
    localparam logic [1:0] DIV_RUN  = 2'd2;
    localparam logic [1:0] FINISH   = 2'd3;

    // Two's-complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1) as an unsigned value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

endpackage

// File: rtl/div_magnitude_core.sv
// One step of unsigned restoring division: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_magnitude_core
    import mult_div_pkg::*;
(
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next_c,
    output logic [WIDTH-1:0] quo_next_c
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The partial remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (trial[WIDTH]) begin
            rem_next_c = shifted[WIDTH-1:0];
            quo_next_c = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_next_c = trial[WIDTH-1:0];
            quo_next_c = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on magnitudes) feeding the HI/LO registers.
module mult_div_unit
    import mult_div_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MULT_OP,
    input  logic             DIV_OP,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             drain, drain_nx;
    logic [WIDTH:0]   acc, acc_nx;
    logic [WIDTH-1:0] qr, qr_nx;
    logic             q_m1, q_m1_nx;
    logic [WIDTH-1:0] m, m_nx;
    logic             neg_quo, neg_quo_nx;
    logic             neg_rem, neg_rem_nx;
    logic [WIDTH-1:0] hi_nx, lo_nx;
    logic             busy_nx, done_nx, div_zero_nx;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH-1:0] rem_step, quo_step;

    div_magnitude_core u_div_core (
        .rem        (acc[WIDTH-1:0]),
        .quo        (qr),
        .divisor    (m),
        .rem_next_c (rem_step),
        .quo_next_c (quo_step)
    );

    // Booth add/subtract of the sign-extended multiplicand, chosen by {Q[0], q-1}.
    always_comb begin
        case ({qr[0], q_m1})
            2'b01:   booth_sum = acc + {m[WIDTH-1], m};
            2'b10:   booth_sum = acc - {m[WIDTH-1], m};
            default: booth_sum = acc;
        endcase
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        drain_nx    = drain;
        acc_nx      = acc;
        qr_nx       = qr;
        q_m1_nx     = q_m1;
        m_nx        = m;
        neg_quo_nx  = neg_quo;
        neg_rem_nx  = neg_rem;
        hi_nx       = HI;
        lo_nx       = LO;
        busy_nx     = busy;
        done_nx     = 1'b0;
        div_zero_nx = 1'b0;

        case (state)
            IDLE: begin
                if (MULT_OP || DIV_OP) begin
                    busy_nx  = 1'b1;
                    cnt_nx   = CNT_W'(ITERS - 1);
                    drain_nx = 1'b0;
                    acc_nx   = '0;
                    q_m1_nx  = 1'b0;
                    if (MULT_OP) begin
                        state_nx = MULT_RUN;
                        qr_nx    = B;
                        m_nx     = A;
                    end else begin
                        state_nx   = DIV_RUN;
                        qr_nx      = magnitude(A);
                        m_nx       = magnitude(B);
                        neg_quo_nx = A[WIDTH-1] ^ B[WIDTH-1];
                        neg_rem_nx = A[WIDTH-1];
                    end
                end
            end

            MULT_RUN: begin
                if (drain) begin
                    state_nx = FINISH;
                    hi_nx    = acc[WIDTH-1:0];
                    lo_nx    = qr;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end else begin
                    acc_nx   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    qr_nx    = {booth_sum[0], qr[WIDTH-1:1]};
                    q_m1_nx  = qr[0];
                    cnt_nx   = cnt - CNT_W'(1);
                    drain_nx = (cnt == '0);
                end
            end

            DIV_RUN: begin
                // A zero divisor finishes without touching HI/LO.
                if (m == '0) begin
                    state_nx    = FINISH;
                    busy_nx     = 1'b0;
                    done_nx     = 1'b1;
                    div_zero_nx = 1'b1;
                end else if (drain) begin
                    state_nx = FINISH;
                    lo_nx    = neg_quo ? (~qr + WIDTH'(1)) : qr;
                    hi_nx    = neg_rem ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end else begin
                    acc_nx   = {1'b0, rem_step};
                    qr_nx    = quo_step;
                    cnt_nx   = cnt - CNT_W'(1);
                    drain_nx = (cnt == '0);
                end
            end

            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            drain    <= 1'b0;
            acc      <= '0;
            qr       <= '0;
            q_m1     <= 1'b0;
            m        <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            HI       <= '0;
            LO       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            drain    <= drain_nx;
            acc      <= acc_nx;
            qr       <= qr_nx;
            q_m1     <= q_m1_nx;
            m        <= m_nx;
            neg_quo  <= neg_quo_nx;
            neg_rem  <= neg_rem_nx;
            HI       <= hi_nx;
            LO       <= lo_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            div_zero <= div_zero_nx;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised self-checking bench for mult_div_unit against a plain 64-bit arithmetic reference.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic        MULT_OP, DIV_OP;
    logic [31:0] HI, LO;
    logic        busy, done, div_zero;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_hi   = '0;
    logic [31:0] exp_lo   = '0;

    mult_div_unit dut (
        .clock    (clock),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .MULT_OP  (MULT_OP),
        .DIV_OP   (DIV_OP),
        .HI       (HI),
        .LO       (LO),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    endtask

    // Reference: signed 64-bit product, or C-style truncating divide; zero divisor leaves HI/LO alone.
    task automatic model(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mult) begin
            r      = sa * sb;
            exp_hi = r[63:32];
            exp_lo = r[31:0];
        end else if (b != 32'd0) begin
            q      = sa / sb;
            r      = sa % sb;
            exp_lo = q[31:0];
            exp_hi = r[31:0];
        end
    endtask

    task automatic run_op(input string tag, input bit mult, input bit div,
                          input logic [31:0] a, input logic [31:0] b, input bit disturb);
        int cycles;
        int busy_cycles;
        bit dz;
        cycles      = 0;
        busy_cycles = 0;
        dz          = !mult && (b == 32'd0);
        @(negedge clock);
        A = a; B = b; MULT_OP = mult; DIV_OP = div;
        @(posedge clock);
        @(negedge clock);
        MULT_OP = 1'b0; DIV_OP = 1'b0;
        while (!done && cycles < 100) begin
            if (busy) busy_cycles++;
            if (disturb && cycles == 5)  DIV_OP = 1'b1;
            if (disturb && cycles == 6)  DIV_OP = 1'b0;
            if (disturb && cycles == 10) A = ~a;
            @(negedge clock);
            cycles++;
        end
        model(mult, a, b);
        check({tag, "_latency"}, 64'(cycles), dz ? 64'd1 : 64'd33);
        check({tag, "_busy_cycles"}, 64'(busy_cycles), dz ? 64'd1 : 64'd33);
        check({tag, "_HI"}, 64'(HI), 64'(exp_hi));
        check({tag, "_LO"}, 64'(LO), 64'(exp_lo));
        check({tag, "_div_zero"}, 64'(div_zero), 64'(dz));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(negedge clock);
        check({tag, "_done_pulse"}, 64'({done, div_zero}), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          kind;
        reset = 1'b0; A = '0; B = '0; MULT_OP = 1'b0; DIV_OP = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_HI", 64'(HI), 64'd0);
        check("reset_LO", 64'(LO), 64'd0);
        check("reset_flags", 64'({busy, done, div_zero}), 64'd0);
        reset = 1'b1;

        run_op("mul_6x7", 1, 0, 32'd6, 32'd7, 0);
        run_op("mul_m3x5", 1, 0, 32'hFFFF_FFFD, 32'd5, 0);
        run_op("mul_min_sq", 1, 0, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("div_100_7", 0, 1, 32'd100, 32'd7, 0);
        run_op("div_overflow", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("div_7_m100", 0, 1, 32'd7, 32'hFFFF_FF9C, 0);
        run_op("preload", 1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run_op("div_by_zero", 0, 1, 32'd10, 32'd0, 0);
        check("dz_busy_after", 64'(busy), 64'd0);

        run_op("disturb", 1, 0, 32'd6, 32'd7, 1);
        repeat (3) begin
            @(negedge clock);
            check("no_second_op", 64'(busy), 64'd0);
        end
        run_op("both_strobes", 1, 1, 32'hFFFF_FFF9, 32'd3, 0);

        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 3));
            ra   = $urandom;
            rb   = $urandom;
            if (kind == 2) rb = 32'($urandom_range(0, 20)) - 32'd10;
            if (kind == 3 && i % 4 == 0) rb = 32'd0;
            run_op("random", kind < 2, kind >= 2, ra, rb, 0);
        end

        // Asynchronous reset between edges while a multiply is in flight.
        run_op("pre_reset", 1, 0, 32'hFFFF_FFFD, 32'd5, 0);
        @(negedge clock);
        A = 32'd6; B = 32'd7; MULT_OP = 1'b1;
        @(posedge clock);
        @(negedge clock);
        MULT_OP = 1'b0;
        repeat (11) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("async_rst_HI", 64'(HI), 64'd0);
        check("async_rst_LO", 64'(LO), 64'd0);
        check("async_rst_flags", 64'({busy, done, div_zero}), 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_idle", 64'({busy, done}), 64'd0);
        run_op("div_after_rst", 0, 1, 32'd100, 32'd7, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
